// File: rtl/fetch_buffer_pkg.sv
// Shared defines for the fetch/decode boundary.
// Holds the fetch buffer geometry and the decoder opcode constants.
package fetch_buffer_pkg;

   localparam int          FB_DEPTH     = 4;
   localparam logic [31:0] FB_NOP_INSTR = 32'h0000_0000;
   localparam int          FB_ENTRY_W   = 65;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_REGIMM  = 6'b000001;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;
   localparam logic [5:0] OP_ADDIU   = 6'b001001;
   localparam logic [5:0] OP_LW      = 6'b100011;
   localparam logic [5:0] OP_SW      = 6'b101011;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        adel;
   } fb_entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-side and decode-side handshakes of the fetch buffer.
// master: fetch/decode environment, slave: the buffer.
interface fetch_buffer_if;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_instr;
   logic        in_adel;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_adel;

   modport master (
      output in_valid,
      output in_pc,
      output in_instr,
      output in_adel,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_pc,
      input  out_instr,
      input  out_adel
   );

   modport slave (
      input  in_valid,
      input  in_pc,
      input  in_instr,
      input  in_adel,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_pc,
      output out_instr,
      output out_adel
   );

endinterface

// File: rtl/fetch_buffer_mem.sv
// Entry storage: DEPTH x 65 registers, one write port, async read.
// Contents are not reset; the controller masks stale data when empty.
module fetch_buffer_mem
   import fetch_buffer_pkg::*;
#(
   parameter int DEPTH = FB_DEPTH,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            we_i,
   input  logic [PW-1:0]   waddr_i,
   input  fb_entry_t       wdata_i,
   input  logic [PW-1:0]   raddr_i,
   output fb_entry_t       rdata_o
);

   fb_entry_t mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer between fetch and decode.
// Registered-output FIFO: no bypass on either side.
module fetch_buffer
   import fetch_buffer_pkg::*;
#(
   parameter int          DEPTH     = FB_DEPTH,
   parameter logic [31:0] NOP_INSTR = FB_NOP_INSTR,
   localparam int         PW        = $clog2(DEPTH),
   localparam int         CW        = PW + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   fetch_buffer_if.slave   bus,
   output logic [CW-1:0]   count
);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic      full;
   logic      empty;
   logic      push;
   logic      pop;
   fb_entry_t wdata;
   fb_entry_t rdata;

   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);
   assign push  = bus.in_valid & ~full & ~flush;
   assign pop   = bus.out_ready & ~empty & ~flush;

   assign wdata = '{pc: bus.in_pc, instr: bus.in_instr, adel: bus.in_adel};

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   fetch_buffer_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (wdata),
      .raddr_i (rd_ptr_q),
      .rdata_o (rdata)
   );

   // Empty buffer presents a NOP so decode never sees stale storage.
   always_comb begin
      bus.out_pc    = '0;
      bus.out_instr = NOP_INSTR;
      bus.out_adel  = 1'b0;
      if (!empty) begin
         bus.out_pc    = rdata.pc;
         bus.out_instr = rdata.instr;
         bus.out_adel  = rdata.adel;
      end
   end

   assign bus.in_ready  = ~full;
   assign bus.out_valid = ~empty;
   assign count         = cnt_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer (DEPTH 4).
// Inputs change #1 after the rising edge; outputs sampled there too.
module tb_fetch_buffer;

   logic       clk;
   logic       rst;
   logic       flush;
   logic [2:0] count;

   int n_chk;
   int n_fail;

   fetch_buffer_if fb ();

   fetch_buffer #(
      .DEPTH     (4),
      .NOP_INSTR (32'h0000_0000)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (fb),
      .count (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic        v,
                        input logic [31:0] pc,
                        input logic [31:0] instr,
                        input logic        adel,
                        input logic        ordy);
      fb.in_valid  = v;
      fb.in_pc     = pc;
      fb.in_instr  = instr;
      fb.in_adel   = adel;
      fb.out_ready = ordy;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst    = 1'b1;
      flush  = 1'b0;
      idle();
      tick();
      tick();

      check("rst_count", 64'(count), 64'd0);
      check("rst_out_valid", 64'(fb.out_valid), 64'd0);
      check("rst_in_ready", 64'(fb.in_ready), 64'd1);
      check("rst_out_instr", 64'(fb.out_instr), 64'h0);
      check("rst_out_pc", 64'(fb.out_pc), 64'h0);
      check("rst_out_adel", 64'(fb.out_adel), 64'd0);
      rst = 1'b0;

      // First push: not visible in the push cycle itself
      drive(1'b1, 32'hBFC0_0000, 32'h2408_0001, 1'b0, 1'b0);
      #1;
      check("push_cyc_instr", 64'(fb.out_instr), 64'h0);
      check("push_cyc_valid", 64'(fb.out_valid), 64'd0);
      tick();
      idle();
      check("first_valid", 64'(fb.out_valid), 64'd1);
      check("first_instr", 64'(fb.out_instr), 64'h2408_0001);
      check("first_pc", 64'(fb.out_pc), 64'hBFC0_0000);
      check("first_count", 64'(count), 64'd1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      tick();
      idle();
      check("first_pop_count", 64'(count), 64'd0);
      check("first_pop_valid", 64'(fb.out_valid), 64'd0);

      // Fill to full with decode stalled
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 1'b0);
         tick();
      end
      check("full_count", 64'(count), 64'd4);
      check("full_in_ready", 64'(fb.in_ready), 64'd0);
      check("full_head_pc", 64'(fb.out_pc), 64'h100);
      drive(1'b1, 32'h300, 32'h300, 1'b0, 1'b0);
      tick();
      check("full_push_count", 64'(count), 64'd4);
      check("stall_hold_pc", 64'(fb.out_pc), 64'h100);
      check("stall_hold_instr", 64'(fb.out_instr), 64'hA0);
      drive(1'b1, 32'h200, 32'h200, 1'b0, 1'b1);
      tick();
      idle();
      check("full_pushpop_count", 64'(count), 64'd3);
      for (int i = 1; i < 4; i++) begin
         check($sformatf("drain_pc%0d", i), 64'(fb.out_pc),
               64'(32'h100 + 32'(4 * i)));
         check($sformatf("drain_instr%0d", i), 64'(fb.out_instr),
               64'(32'hA0 + 32'(i)));
         drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
         tick();
      end
      idle();
      check("drain_count", 64'(count), 64'd0);
      check("drain_valid", 64'(fb.out_valid), 64'd0);

      // Streaming: one in, one out per cycle, pointers wrap
      drive(1'b1, 32'h8000_0000, 32'hC0, 1'b0, 1'b0);
      tick();
      for (int i = 1; i < 10; i++) begin
         check($sformatf("stream_pc%0d", i - 1), 64'(fb.out_pc),
               64'(32'h8000_0000 + 32'(4 * (i - 1))));
         check($sformatf("stream_instr%0d", i - 1), 64'(fb.out_instr),
               64'(32'hC0 + 32'(i - 1)));
         drive(1'b1, 32'h8000_0000 + 32'(4 * i), 32'hC0 + 32'(i),
               1'b0, 1'b1);
         tick();
         check($sformatf("stream_count%0d", i), 64'(count), 64'd1);
      end
      idle();
      check("stream_last_pc", 64'(fb.out_pc), 64'h8000_0024);
      check("stream_last_instr", 64'(fb.out_instr), 64'hC9);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      tick();
      idle();
      check("stream_end_count", 64'(count), 64'd0);

      // Address-error flag travels with the entry
      drive(1'b1, 32'h0000_0003, 32'h1234_5678, 1'b1, 1'b0);
      tick();
      idle();
      check("adel_flag", 64'(fb.out_adel), 64'd1);
      check("adel_pc", 64'(fb.out_pc), 64'h3);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      tick();
      idle();
      check("adel_pop_adel", 64'(fb.out_adel), 64'd0);

      // Flush beats simultaneous push and pop
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h400 + 32'(4 * i), 32'hD0 + 32'(i), 1'b0, 1'b0);
         tick();
      end
      check("preflush_count", 64'(count), 64'd3);
      flush = 1'b1;
      drive(1'b1, 32'h500, 32'h500, 1'b0, 1'b1);
      tick();
      flush = 1'b0;
      idle();
      check("flush_count", 64'(count), 64'd0);
      check("flush_valid", 64'(fb.out_valid), 64'd0);
      check("flush_instr", 64'(fb.out_instr), 64'h0);
      check("flush_in_ready", 64'(fb.in_ready), 64'd1);
      drive(1'b1, 32'h600, 32'hE0, 1'b0, 1'b0);
      tick();
      idle();
      check("postflush_pc", 64'(fb.out_pc), 64'h600);
      check("postflush_count", 64'(count), 64'd1);

      // Reset mid-operation with a push pending
      drive(1'b1, 32'h604, 32'hE1, 1'b0, 1'b0);
      tick();
      check("prerst_count", 64'(count), 64'd2);
      rst = 1'b1;
      drive(1'b1, 32'h608, 32'hE2, 1'b0, 1'b1);
      tick();
      rst = 1'b0;
      idle();
      check("midrst_count", 64'(count), 64'd0);
      check("midrst_valid", 64'(fb.out_valid), 64'd0);
      check("midrst_in_ready", 64'(fb.in_ready), 64'd1);
      check("midrst_instr", 64'(fb.out_instr), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4: number of entries; SHALL be a power of two, 2 to 16.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000: instruction word driven on out_instr while empty.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  discard all buffered and incoming entries (exception or branch redirect).
REQ-006 in_valid  input  1  fetch presents an entry.
REQ-007 in_ready  output  1  buffer accepts an entry this cycle.
REQ-008 in_pc  input  32  PC of the incoming instruction.
REQ-009 in_instr  input  32  fetched instruction word.
REQ-010 in_adel  input  1  fetch address-error flag attached to the entry.
REQ-011 out_valid  output  1  head entry is valid for decode.
REQ-012 out_ready  input  1  decode consumes the head this cycle (decode not stalled).
REQ-013 out_pc  output  32  head PC.
REQ-014 out_instr  output  32  head instruction; this is the instrD word fed to decode.
REQ-015 out_adel  output  1  head address-error flag.
REQ-016 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-017 Push: in_valid & in_ready & ~flush SHALL write {in_pc, in_instr, in_adel} at the write pointer and advance it modulo DEPTH.
REQ-018 Pop: out_valid & out_ready & ~flush SHALL advance the read pointer modulo DEPTH.
REQ-019 in_ready SHALL equal (count != DEPTH); no bypass, so a full buffer rejects a push even when a pop occurs in the same cycle.
REQ-020 out_valid SHALL equal (count != 0); out_* are driven from storage, so a pushed entry first appears on the outputs in the cycle after the push (latency 1, no empty-buffer bypass).
REQ-021 While empty: out_instr SHALL be NOP_INSTR, out_pc 0 and out_adel 0.
REQ-022 count next value: +1 on push only; -1 on pop only; unchanged on simultaneous push and pop, or on neither.
REQ-023 flush SHALL take priority over push and pop: next cycle count=0, both pointers 0, the incoming entry is dropped, and in_ready is 1.
REQ-024 Pointers SHALL wrap from DEPTH-1 to 0 with no loss of entries; ordering is strictly FIFO.
REQ-025 out_* SHALL remain stable while out_valid & ~out_ready & ~flush.
REQ-026 A pop when empty or a push when full SHALL have no effect on state.

Reset
REQ-027 While rst is high at a clock edge: count=0, pointers=0, out_valid=0, in_ready=1, out_instr=NOP_INSTR, out_pc=0, out_adel=0.
REQ-028 rst SHALL override flush, push and pop; entries in flight when rst asserts mid-operation are lost.
REQ-029 Storage array contents need no reset; emptiness gating (REQ-021) masks stale data.

Structure
REQ-030 DEPTH default, NOP_INSTR and entry width (65 bits) SHALL be defined in the shared defines package next to the decoder opcode constants.
REQ-031 Storage SHALL be a single sub-module, fetch_buffer_mem: DEPTH x 65 register array, one write port, one asynchronous read port, no reset.
REQ-032 Control (pointers, count, ready/valid) SHALL reside in fetch_buffer.

Verification
REQ-033 After reset, push PC 0xBFC00000 / instr 0x24080001 -> next cycle out_valid=1, out_instr=0x24080001, count=1; in the push cycle itself out_instr=0x00000000.
REQ-034 Push 4 entries with out_ready=0 -> count=4, in_ready=0; a 5th push plus a pop in the same cycle -> only the pop takes effect, count=3, the 5th entry is not stored.
REQ-035 Continuous push and pop over 10 entries (PCs 0x...00 to 0x...24) -> every entry appears in order, count stays 1, pointers wrap twice.
REQ-036 Buffer holds 3 entries; assert flush together with in_valid and out_ready -> next cycle count=0, out_valid=0, out_instr=0, in_ready=1.
REQ-037 Push an entry with in_adel=1 at PC 0x00000003 -> out_adel=1, out_pc=0x00000003 on the output.
REQ-038 Buffer holds 2 entries; assert rst -> next cycle count=0, out_valid=0, in_ready=1.
